// File: rtl/load_arbiter8.sv
// Round-robin arbiter for one register-bank write port shared by eight requesters.
// Issues a registered one-hot load strobe, the matching mux select and a valid flag; supports bounded locked bursts.
module load_arbiter8 #(
    parameter int MAX_LOCK = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] lock,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

    state_t     state;
    logic [2:0] ptr;
    logic [3:0] cnt;

    logic [7:0] cand;
    logic [2:0] start;
    logic [2:0] sel_next;
    logic       hit;
    logic [2:0] win;
    logic       hold;

    // Scan v from index first upward with wrap; the lowest offset that is set wins.
    function automatic logic [3:0] find_first(input logic [7:0] v, input logic [2:0] first);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int k = 7; k >= 0; k--) begin
            idx = first + 3'(k);
            if (v[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel_next = sel + 3'd1;
        cand     = req;
        start    = ptr;
        hold     = 1'b0;
        if (state == GRANT) begin
            cand  = req & ~(8'b1 << sel);
            start = sel_next;
            hold  = req[sel] & lock[sel] & (cnt < MAX_CNT);
        end
        {hit, win} = find_first(cand, start);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 3'd0;
            cnt   <= 4'd0;
            grant <= 8'h00;
            sel   <= 3'd0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        state <= GRANT;
                        grant <= 8'b1 << win;
                        sel   <= win;
                        valid <= 1'b1;
                        cnt   <= 4'd1;
                    end
                end
                GRANT: begin
                    if (hold) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        // Release: the rotation restarts just past the holder, which is masked out.
                        ptr <= sel_next;
                        if (hit) begin
                            grant <= 8'b1 << win;
                            sel   <= win;
                            cnt   <= 4'd1;
                        end else begin
                            state <= IDLE;
                            grant <= 8'h00;
                            sel   <= 3'd0;
                            valid <= 1'b0;
                            cnt   <= 4'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_arbiter8.sv
// Scoreboard bench for load_arbiter8: each driven cycle queues the required strobe, checked one edge later.
module tb_load_arbiter8;

    typedef struct {
        string      tag;
        logic [7:0] grant;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] req   = 8'h00;
    logic [7:0] lock  = 8'h00;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       valid;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    load_arbiter8 #(.MAX_LOCK(4)) dut (
        .clock(clock),
        .reset(reset),
        .req  (req),
        .lock (lock),
        .grant(grant),
        .sel  (sel),
        .valid(valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] index_of(input logic [7:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++)
            if (g[i]) r = 3'(i);
        return r;
    endfunction

    // Drive one cycle of inputs, queue the strobe required after the next edge, then compare.
    task automatic step(input logic [7:0] r, input logic [7:0] l, input logic [7:0] eg, input string tag);
        exp_t e;
        req  = r;
        lock = l;
        sb.push_back('{tag, eg});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check({e.tag, ".grant"}, 32'(grant), 32'(e.grant));
        check({e.tag, ".sel"},   32'(sel),   32'(index_of(e.grant)));
        check({e.tag, ".valid"}, 32'(valid), 32'(e.grant != 8'h00));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".grant"}, 32'(grant), 32'h00);
        check({tag, ".sel"},   32'(sel),   32'h0);
        check({tag, ".valid"}, 32'(valid), 32'h0);
    endtask

    task automatic apply_reset(input string tag);
        req   = 8'h00;
        lock  = 8'h00;
        reset = 1'b1;
        #2;
        check_idle(tag);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2;
        apply_reset("reset0");

        // Single one-cycle request.
        step(8'h20, 8'h00, 8'h20, "single");
        step(8'h00, 8'h00, 8'h00, "single_off");
        step(8'h00, 8'h00, 8'h00, "single_idle");

        // Fairness with every requester persistent.
        apply_reset("reset_rr");
        for (int i = 0; i < 9; i++)
            step(8'hFF, 8'h00, 8'(1 << (i % 8)), $sformatf("rr%0d", i));
        step(8'h00, 8'h00, 8'h00, "rr_end");

        // Rotation restarts after the released requester.
        apply_reset("reset_rot");
        step(8'h04, 8'h00, 8'h04, "rot_g2");
        step(8'h05, 8'h00, 8'h01, "rot_g0");
        step(8'h05, 8'h00, 8'h04, "rot_g2b");
        step(8'h0C, 8'h00, 8'h08, "rot_g3");
        step(8'h00, 8'h00, 8'h00, "rot_end");

        // Locked burst bounded at four cycles.
        apply_reset("reset_lk");
        begin
            logic [7:0] burst [10];
            burst = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h08, 8'h01, 8'h01, 8'h01, 8'h01, 8'h08};
            for (int i = 0; i < 10; i++)
                step(8'h09, 8'h01, burst[i], $sformatf("lk%0d", i));
        end
        step(8'h00, 8'h00, 8'h00, "lk_end");

        // Early unlock: the released requester sits out the release cycle.
        apply_reset("reset_eu");
        step(8'h01, 8'h01, 8'h01, "eu0");
        step(8'h01, 8'h01, 8'h01, "eu1");
        step(8'h01, 8'h00, 8'h00, "eu_gap");
        step(8'h01, 8'h00, 8'h01, "eu_again");
        step(8'h00, 8'h00, 8'h00, "eu_end");

        // Reset between edges during a locked grant clears outputs at once.
        step(8'h40, 8'h40, 8'h40, "mid0");
        step(8'h40, 8'h40, 8'h40, "mid1");
        #2;
        reset = 1'b1;
        #1;
        check_idle("mid_reset");
        req  = 8'h00;
        lock = 8'h00;
        @(negedge clock);
        reset = 1'b0;
        step(8'h01, 8'h00, 8'h01, "post_reset");
        step(8'h00, 8'h00, 8'h00, "post_end");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
